rv32i_decode_execute: RTL and testbench

Decode-and-execute slice of the 3-stage RV32I pipeline. It decodes a raw fetched instruction combinationally and latches the decoded record into an execute register. In the following cycle it computes the ALU result, the branch/jump decision and target, and the data-memory request. Register-file access and forwarding live outside; this block receives already-forwarded operand values.

---
 rtl/rv32i_decode_execute_pkg.sv | 77 +++++++
 rtl/rv32i_decode_execute_if.sv | 18 +
 rtl/rv32i_decode_execute_units.sv | 192 +++++++++++++++++++
 rtl/rv32i_decode_execute.sv | 107 ++++++++++
 tb/tb_rv32i_decode_execute.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_decode_execute_pkg.sv
// rv32i_pkg: shared types for the RV32I decode/execute slice.
//   dec_t         - decoded-instruction record latched into the execute register
//   alu_op_e      - ALU operation selector (ALU_ADD is the all-zero encoding)
//   OPC_* / BR_*  - major opcodes and branch funct3 codes
//   alu_op_decode - funct3/funct7 to ALU op mapping shared by OP and OP-IMM
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        rs1_pc;       // operand A is pc instead of rs1
    logic        rs2_imm;      // operand B is imm instead of rs2
    logic        branch;
    logic [2:0]  branch_type;  // funct3 of the branch
    logic        jump;
    logic [2:0]  loadstore;    // [2] = store, [1:0] = width (1 B, 2 H, 3 W), 0 = none
    logic        load_zext;
  } dec_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // instr[30] selects SUB only in the register form; ADDI may carry any bit 30.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3,
                                            input logic       alt,
                                            input logic       reg_form);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode_execute_if.sv
// Data-memory request bus from the execute stage.
//   mem_addr  - effective address (rs1 + imm)
//   mem_wdata - store data (rs2)
//   mem_width - 1 byte, 2 half, 3 word
//   mem_we / mem_re - store / load request
//   mem_zext  - zero-extend the loaded value
// master: execute stage (drives request); slave: memory side.
interface rv32i_decode_execute_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_we;
  logic        mem_re;
  logic        mem_zext;

  modport master (output mem_addr, mem_wdata, mem_width, mem_we, mem_re, mem_zext);
  modport slave  (input  mem_addr, mem_wdata, mem_width, mem_we, mem_re, mem_zext);
endinterface

// File: rtl/rv32i_decode_execute_units.sv
// Combinational building blocks of the decode/execute slice.
//   rv32_decoder    : instr, pc -> dec (decoded record; unknown encodings give all-zero)
//   rv32_alu        : op, a, b  -> result, sum (sum = a + b always)
//   rv32_branch_cmp : br_type, a, b -> take
module rv32_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output dec_t        dec
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s  = {instr[31:12], 12'd0};
  assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode-driven field selection; every field not set stays zero.
  always_comb begin
    dec = '0;
    case (opcode_s)
      OPC_LUI: begin
        dec.valid   = 1'b1;
        dec.pc      = pc;
        dec.rd_addr = instr[11:7];
        dec.imm     = imm_u_s;
        dec.alu_op  = ALU_PASSB;
        dec.rs2_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.valid   = 1'b1;
        dec.pc      = pc;
        dec.rd_addr = instr[11:7];
        dec.imm     = imm_u_s;
        dec.rs1_pc  = 1'b1;
        dec.rs2_imm = 1'b1;
      end
      OPC_JAL: begin
        dec.valid   = 1'b1;
        dec.pc      = pc;
        dec.rd_addr = instr[11:7];
        dec.imm     = imm_j_s;
        dec.jump    = 1'b1;
        dec.rs1_pc  = 1'b1;
        dec.rs2_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.valid    = 1'b1;
        dec.pc       = pc;
        dec.rs1_addr = instr[19:15];
        dec.rd_addr  = instr[11:7];
        dec.imm      = imm_i_s;
        dec.jump     = 1'b1;
        dec.rs2_imm  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.valid       = 1'b1;
        dec.pc          = pc;
        dec.rs1_addr    = instr[19:15];
        dec.rs2_addr    = instr[24:20];
        dec.imm         = imm_b_s;
        dec.branch      = 1'b1;
        dec.branch_type = funct3_s;
        dec.rs1_pc      = 1'b1;
        dec.rs2_imm     = 1'b1;
      end
      OPC_LOAD: begin
        // Only LB/LH/LW/LBU/LHU are legal; the rest decode as a bubble.
        if ((funct3_s[1:0] != 2'b11) && !(funct3_s[2] && funct3_s[1])) begin
          dec.valid     = 1'b1;
          dec.pc        = pc;
          dec.rs1_addr  = instr[19:15];
          dec.rd_addr   = instr[11:7];
          dec.imm       = imm_i_s;
          dec.rs2_imm   = 1'b1;
          dec.loadstore = {1'b0, funct3_s[1:0] + 2'd1};
          dec.load_zext = funct3_s[2];
        end else begin
          dec = '0;
        end
      end
      OPC_STORE: begin
        if (!funct3_s[2] && (funct3_s[1:0] != 2'b11)) begin
          dec.valid     = 1'b1;
          dec.pc        = pc;
          dec.rs1_addr  = instr[19:15];
          dec.rs2_addr  = instr[24:20];
          dec.imm       = imm_s_s;
          dec.rs2_imm   = 1'b1;
          dec.loadstore = {1'b1, funct3_s[1:0] + 2'd1};
        end else begin
          dec = '0;
        end
      end
      OPC_OP_IMM: begin
        dec.valid    = 1'b1;
        dec.pc       = pc;
        dec.rs1_addr = instr[19:15];
        dec.rd_addr  = instr[11:7];
        dec.imm      = imm_i_s;
        dec.rs2_imm  = 1'b1;
        dec.alu_op   = alu_op_decode(funct3_s, instr[30], 1'b0);
      end
      OPC_OP: begin
        dec.valid    = 1'b1;
        dec.pc       = pc;
        dec.rs1_addr = instr[19:15];
        dec.rs2_addr = instr[24:20];
        dec.rd_addr  = instr[11:7];
        dec.alu_op   = alu_op_decode(funct3_s, instr[30], 1'b1);
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.valid = 1'b1;
        dec.pc    = pc;
      end
      default: dec = '0;
    endcase
  end

endmodule

module rv32_alu
  import rv32i_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [31:0] sum
);

  logic [4:0] shamt_s;

  assign sum     = a + b;
  assign shamt_s = b[4:0];

  // Operation select; sum is reused for ADD.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:   result = sum;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt_s;
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt_s;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt_s);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = sum;
    endcase
  end

endmodule

module rv32_branch_cmp
  import rv32i_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        take
);

  // funct3 010/011 are not branch encodings and never take.
  always_comb begin
    take = 1'b0;
    case (br_type)
      BR_EQ:   take = (a == b);
      BR_NE:   take = (a != b);
      BR_LT:   take = ($signed(a) <  $signed(b));
      BR_GE:   take = ($signed(a) >= $signed(b));
      BR_LTU:  take = (a <  b);
      BR_GEU:  take = (a >= b);
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_execute.sv
// Decode/execute slice of a 3-stage RV32I pipeline.
// Decodes i_instr/i_pc into an execute register; the execute stage then
// produces ALU result, redirect decision/target and the memory request
// combinationally from that register and forwarded i_rs1/i_rs2.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_instr, i_pc           - fetched instruction and its PC
//   i_rs1, i_rs2            - forwarded operands of the execute-stage instruction
//   o_rs1_addr/o_rs2_addr/o_rd_addr - execute-stage register indices
//   o_alu_out, o_alu_sum    - ALU result and raw A+B
//   o_redirect, o_target, o_link, o_is_jump - control-flow outputs
//   o_ex_valid              - execute stage holds a legal instruction
//   mem_bus (master)        - data-memory request
module rv32i_decode_execute
  import rv32i_pkg::*;
#(
  parameter logic [31:0] INIT_PC = 32'h10000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_alu_out,
  output logic [31:0] o_alu_sum,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_link,
  output logic        o_is_jump,
  output logic        o_ex_valid,
  rv32i_decode_execute_if.master mem_bus
);

  // INIT_PC is carried only so fetch and this block share one parameter set.
  logic [31:0] unused_init_pc_s;
  assign unused_init_pc_s = INIT_PC;

  dec_t        dec_s;
  dec_t        ex_r = '0;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  logic [31:0] alu_out_s;
  logic [31:0] alu_sum_s;
  logic        br_take_s;
  logic        is_jalr_s;
  logic        redirect_s;

  rv32_decoder u_decoder (
    .instr (i_instr),
    .pc    (i_pc),
    .dec   (dec_s)
  );

  // Execute register: a redirect squashes the fall-through instruction behind it.
  always_ff @(posedge i_clk) begin
    if (i_rst || redirect_s) begin
      ex_r <= '0;
    end else begin
      ex_r <= dec_s;
    end
  end

  assign op_a_s = ex_r.rs1_pc  ? ex_r.pc  : i_rs1;
  assign op_b_s = ex_r.rs2_imm ? ex_r.imm : i_rs2;

  rv32_alu u_alu (
    .op     (ex_r.alu_op),
    .a      (op_a_s),
    .b      (op_b_s),
    .result (alu_out_s),
    .sum    (alu_sum_s)
  );

  rv32_branch_cmp u_branch_cmp (
    .br_type (ex_r.branch_type),
    .a       (i_rs1),
    .b       (i_rs2),
    .take    (br_take_s)
  );

  // JALR is the only jump whose A operand is rs1 rather than pc.
  assign is_jalr_s  = ex_r.jump & ~ex_r.rs1_pc;
  assign redirect_s = ex_r.jump | (ex_r.branch & br_take_s);

  assign o_rs1_addr = ex_r.rs1_addr;
  assign o_rs2_addr = ex_r.rs2_addr;
  assign o_rd_addr  = ex_r.rd_addr;
  assign o_alu_out  = alu_out_s;
  assign o_alu_sum  = alu_sum_s;
  assign o_redirect = redirect_s;
  assign o_target   = {alu_sum_s[31:1], alu_sum_s[0] & ~is_jalr_s};
  assign o_link     = ex_r.pc + 32'd4;
  assign o_is_jump  = ex_r.jump;
  assign o_ex_valid = ex_r.valid;

  assign mem_bus.mem_addr  = i_rs1 + ex_r.imm;
  assign mem_bus.mem_wdata = i_rs2;
  assign mem_bus.mem_width = ex_r.loadstore[1:0];
  assign mem_bus.mem_re    = ~ex_r.loadstore[2] & (ex_r.loadstore[1:0] != 2'd0);
  assign mem_bus.mem_we    =  ex_r.loadstore[2] & (ex_r.loadstore[1:0] != 2'd0);
  assign mem_bus.mem_zext  = ex_r.load_zext;

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed testbench for rv32i_decode_execute. Each step presents an
// instruction, lets it latch, then applies execute-stage operands and checks
// the combinational execute outputs against hand-computed values.
module tb_rv32i_decode_execute;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_alu_out;
  logic [31:0] o_alu_sum;
  logic        o_redirect;
  logic [31:0] o_target;
  logic [31:0] o_link;
  logic        o_is_jump;
  logic        o_ex_valid;

  int checks   = 0;
  int failures = 0;

  rv32i_decode_execute_if mem_bus ();

  rv32i_decode_execute #(.INIT_PC(32'h10000000)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_rd_addr  (o_rd_addr),
    .o_alu_out  (o_alu_out),
    .o_alu_sum  (o_alu_sum),
    .o_redirect (o_redirect),
    .o_target   (o_target),
    .o_link     (o_link),
    .o_is_jump  (o_is_jump),
    .o_ex_valid (o_ex_valid),
    .mem_bus    (mem_bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present instr/pc, clock it into execute, then apply operands.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    i_instr = instr;
    i_pc    = pc;
    @(posedge i_clk);
    #1;
    i_rs1 = rs1;
    i_rs2 = rs2;
    #1;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_instr = 32'h00500093;
    i_pc    = 32'h10000000;
    i_rs1   = 32'd0;
    i_rs2   = 32'd0;

    // Reset: bubble even though a legal instruction is presented.
    @(posedge i_clk);
    #1;
    i_rs1 = 32'd7;
    i_rs2 = 32'd9;
    #1;
    check("rst_valid",    {31'd0, o_ex_valid}, 32'd0);
    check("rst_redirect", {31'd0, o_redirect}, 32'd0);
    check("rst_rd",       {27'd0, o_rd_addr},  32'd0);
    check("rst_link",     o_link,              32'd4);
    check("rst_alu",      o_alu_out,           32'd16);
    i_rst = 1'b0;

    // addi x1,x0,5
    step(32'h00500093, 32'h10000000, 32'd0, 32'd0);
    check("addi_valid", {31'd0, o_ex_valid}, 32'd1);
    check("addi_rd",    {27'd0, o_rd_addr},  32'd1);
    check("addi_alu",   o_alu_out,           32'd5);

    // sub x3,x1,x2 : 3-5
    step(32'h402081B3, 32'h10000004, 32'd3, 32'd5);
    check("sub_alu",  o_alu_out,           32'hFFFFFFFE);
    check("sub_sum",  o_alu_sum,           32'd8);
    check("sub_rs1",  {27'd0, o_rs1_addr}, 32'd1);
    check("sub_rs2",  {27'd0, o_rs2_addr}, 32'd2);

    // sra x4,x1,x2 : shift amount comes from B[4:0] only (0x24 -> 4)
    step(32'h4020D233, 32'h10000008, 32'h80000000, 32'h00000024);
    check("sra_alu", o_alu_out, 32'hF8000000);

    // sltu / slt with 1 vs 0xFFFFFFFF
    step(32'h0020B2B3, 32'h1000000C, 32'd1, 32'hFFFFFFFF);
    check("sltu_alu", o_alu_out, 32'd1);
    step(32'h0020A2B3, 32'h10000010, 32'd1, 32'hFFFFFFFF);
    check("slt_alu", o_alu_out, 32'd0);

    // lui x7,0x12345
    step(32'h123453B7, 32'h10000014, 32'hAAAA5555, 32'd0);
    check("lui_alu", o_alu_out,           32'h12345000);
    check("lui_rs1", {27'd0, o_rs1_addr}, 32'd0);

    // beq x1,x2,+8 not taken
    step(32'h00208463, 32'h10000010, 32'd1, 32'd2);
    check("beq_nt_redirect", {31'd0, o_redirect}, 32'd0);

    // funct3 010 is never taken even with equal operands
    step(32'h0020A463, 32'h10000010, 32'd5, 32'd5);
    check("br010_redirect", {31'd0, o_redirect}, 32'd0);

    // beq taken, then the fall-through instruction is squashed
    step(32'h00208463, 32'h10000010, 32'd5, 32'd5);
    check("beq_redirect", {31'd0, o_redirect}, 32'd1);
    check("beq_target",   o_target,            32'h10000018);
    check("beq_rd",       {27'd0, o_rd_addr},  32'd0);
    step(32'h00500093, 32'h10000014, 32'd7, 32'd9);
    check("beq_kill_valid", {31'd0, o_ex_valid}, 32'd0);
    check("bubble_sum",     o_alu_sum,           32'd16);

    // jal x1,+16
    step(32'h010000EF, 32'h10000000, 32'd0, 32'd0);
    check("jal_target", o_target,            32'h10000010);
    check("jal_link",   o_link,              32'h10000004);
    check("jal_jump",   {31'd0, o_is_jump},  32'd1);
    check("jal_rd",     {27'd0, o_rd_addr},  32'd1);

    // jalr x1,0(x2): first presentation is killed by the JAL
    step(32'h000100E7, 32'h10000040, 32'h10000021, 32'd0);
    check("jal_kill_valid", {31'd0, o_ex_valid}, 32'd0);
    step(32'h000100E7, 32'h10000040, 32'h10000021, 32'd0);
    check("jalr_target",   o_target,            32'h10000020);
    check("jalr_redirect", {31'd0, o_redirect}, 32'd1);
    check("jalr_link",     o_link,              32'h10000044);

    // lbu x3,4(x2): first presentation killed by the JALR
    step(32'h00414183, 32'h10000080, 32'h20000000, 32'd0);
    step(32'h00414183, 32'h10000080, 32'h20000000, 32'd0);
    check("lbu_addr",  mem_bus.mem_addr,               32'h20000004);
    check("lbu_re",    {31'd0, mem_bus.mem_re},        32'd1);
    check("lbu_we",    {31'd0, mem_bus.mem_we},        32'd0);
    check("lbu_width", {30'd0, mem_bus.mem_width},     32'd1);
    check("lbu_zext",  {31'd0, mem_bus.mem_zext},      32'd1);
    check("lbu_rd",    {27'd0, o_rd_addr},             32'd3);

    // sw x2,8(x1)
    step(32'h0020A423, 32'h10000084, 32'h00000100, 32'hDEADBEEF);
    check("sw_we",    {31'd0, mem_bus.mem_we},    32'd1);
    check("sw_re",    {31'd0, mem_bus.mem_re},    32'd0);
    check("sw_rd",    {27'd0, o_rd_addr},         32'd0);
    check("sw_width", {30'd0, mem_bus.mem_width}, 32'd3);
    check("sw_addr",  mem_bus.mem_addr,           32'h00000108);
    check("sw_wdata", mem_bus.mem_wdata,          32'hDEADBEEF);

    // Unknown opcode decodes to a bubble
    step(32'hFFFFFFFF, 32'h10000088, 32'd0, 32'd0);
    check("unk_valid", {31'd0, o_ex_valid}, 32'd0);

    // Mid-stream reset flushes on the next edge
    step(32'h00500093, 32'h1000008C, 32'd0, 32'd0);
    check("pre_rst_valid", {31'd0, o_ex_valid}, 32'd1);
    i_rst = 1'b1;
    step(32'h00500093, 32'h10000090, 32'd0, 32'd0);
    check("mid_rst_valid", {31'd0, o_ex_valid}, 32'd0);
    check("mid_rst_rd",    {27'd0, o_rd_addr},  32'd0);
    i_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
